// File: rtl/i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_rx_fifo
//
// I2S receive front end for a mono (left-slot) microphone, plus a small
// show-ahead sample FIFO read by the AHB-lite I2S wrapper.
//
// The block is the I2S bus master. It generates SCK and WS from HCLK and
// captures SD MSB-first during the left slot only. Each completed sample is
// sign-extended to 32 bits and pushed into the FIFO. The FIFO head is always
// visible on rd_data.
//
// Parameters
//   DEPTH        FIFO entries; a power of two from 2 to 16.
//   SAMPLE_BITS  captured bits per sample, 1..31.
//
// Ports
//   HCLK      in   sole clock; all state changes on its rising edge
//   HRESETn   in   asynchronous active-low reset
//   en        in   capture enable; while low the I2S side is held idle
//   clk_div   in   SCK divider; SCK period = 2*(clk_div+1) HCLK cycles.
//                  Change it only while en=0.
//   SD        in   I2S serial data from the microphone
//   SCK       out  I2S bit clock (registered)
//   WS        out  I2S word select (registered); 0 selects the left slot
//   rd_en     in   pop request; ignored while the FIFO is empty
//   rd_data   out  FIFO head sample, sign-extended; 0 while empty
//   empty     out  FIFO holds no samples
//   full      out  FIFO holds DEPTH samples
//   level     out  FIFO occupancy, 0..DEPTH
//   flush     in   synchronous FIFO clear; wins over a same-cycle push/pop
//   overflow  out  sticky flag: a sample was dropped because the FIFO was full
//   clr_ovf   in   clears overflow; a same-cycle overflow event wins
// -----------------------------------------------------------------------------
module i2s_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int SAMPLE_BITS = 24
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        en,
    input  logic [7:0]  clk_div,
    input  logic        SD,
    output logic        SCK,
    output logic        WS,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        empty,
    output logic        full,
    output logic [4:0]  level,
    input  logic        flush,
    output logic        overflow,
    input  logic        clr_ovf
);

    // Pointer width. DEPTH is a power of two, so the pointers wrap by
    // themselves at the end of the array.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The shift register keeps the bits that arrived before the current
    // one. The current SD bit is appended on the fly. This lets the push
    // use the word that includes the last bit in the same cycle it is
    // sampled.
    localparam int SW = (SAMPLE_BITS > 1) ? (SAMPLE_BITS - 1) : 1;

    localparam logic [5:0] LAST_BIT  = 6'(SAMPLE_BITS);
    localparam logic [4:0] DEPTH_LVL = 5'(DEPTH);

    // -------------------------------------------------------------------------
    // I2S timing and capture state
    // -------------------------------------------------------------------------
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic          sck_q, sck_d;
    logic          ws_q, ws_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] shift_q, shift_d;

    logic          sck_rise;       // this cycle's SCK toggle is 0 -> 1
    logic          sck_fall;       // this cycle's SCK toggle is 1 -> 0
    logic          capture_slot;   // bit_cnt points at a sample bit of the left slot
    logic          push;           // a completed sample is available this cycle

    logic [SAMPLE_BITS-1:0] shift_in;   // completed bits including this cycle's SD
    logic [31:0]            push_word;  // shift_in sign-extended to 32 bits

    generate
        if (SAMPLE_BITS > 1) begin : g_shift_wide
            assign shift_in = {shift_q, SD};
        end else begin : g_shift_single
            assign shift_in = SD;
        end
    endgenerate

    // Replicate the sample MSB into the upper bits of the word.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sext
            if (gi < SAMPLE_BITS) begin : g_data
                assign push_word[gi] = shift_in[gi];
            end else begin : g_sign
                assign push_word[gi] = shift_in[SAMPLE_BITS-1];
            end
        end
    endgenerate

    // Bit 0 of the left slot is the I2S one-bit delay, so it is skipped.
    // Bits past the sample width and the whole right slot are ignored.
    assign capture_slot = (bit_cnt_q[5] == 1'b0)
                        && (bit_cnt_q != 6'd0)
                        && (bit_cnt_q <= LAST_BIT);

    always_comb begin : serial_next
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        ws_d      = ws_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sck_rise  = 1'b0;
        sck_fall  = 1'b0;
        push      = 1'b0;

        if (!en) begin
            // Idle bus. Any partial word is discarded. The first toggle
            // after re-enable is then a rising edge at bit_cnt 0, which is
            // the delay bit.
            div_cnt_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            if (div_cnt_q == clk_div) begin
                div_cnt_d = '0;
                sck_d     = ~sck_q;
                sck_rise  = ~sck_q;
                sck_fall  = sck_q;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end

            // WS is updated together with the falling SCK edge that moves
            // bit_cnt into the new slot, so it always equals bit_cnt[5].
            if (sck_fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                ws_d      = bit_cnt_d[5];
            end

            if (sck_rise && capture_slot) begin
                shift_d = shift_in[SW-1:0];
                if (bit_cnt_q == LAST_BIT) begin
                    push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin : serial_regs
        if (!HRESETn) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign SCK = sck_q;
    assign WS  = ws_q;

    // -------------------------------------------------------------------------
    // Sample FIFO
    // -------------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          ovf_q, ovf_d;

    logic          do_pop;     // pop accepted this cycle
    logic          push_ok;    // push that will be written this cycle
    logic          ovf_event;  // push dropped because the FIFO is full
    logic          mem_we;

    assign empty = (level_q == 5'd0);
    assign full  = (level_q == DEPTH_LVL);

    assign do_pop = rd_en & ~empty;

    // A pop in the same cycle frees the slot, so a push is accepted even
    // when the FIFO is full.
    assign push_ok = push & (~full | do_pop);

    // A flush discards the incoming sample, but that is not counted as an
    // overflow.
    assign ovf_event = push & full & ~do_pop & ~flush;

    always_comb begin : fifo_next
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_we   = 1'b0;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !do_pop) begin
                level_d = level_q + 5'd1;
            end else if (!push_ok && do_pop) begin
                level_d = level_q - 5'd1;
            end
        end

        // A new overflow in the same cycle wins over a clear.
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin : fifo_regs
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage has no reset. The head is masked to zero while the FIFO is
    // empty, so stale or uninitialised entries never show on rd_data.
    always_ff @(posedge HCLK) begin : fifo_mem
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign rd_data  = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_fifo
//
// Directed bench for i2s_rx_fifo with default parameters (DEPTH=8,
// SAMPLE_BITS=24) and clk_div=1. With those settings:
//   SCK period    = 4 HCLK
//   frame length  = 256 HCLK
//   sample push   = 98 HCLK after enable, plus 256 per frame
//
// A microphone model drives SD from the DUT's SCK/WS. Left words come from
// the vector table. The right slot and every non-sample bit are driven as 1,
// so a capture of the wrong bit shows up in the data.
// -----------------------------------------------------------------------------
module tb_i2s_rx_fifo;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        en;
    logic [7:0]  clk_div;
    logic        SD;
    logic        SCK;
    logic        WS;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        flush;
    logic        overflow;
    logic        clr_ovf;

    i2s_rx_fifo #(
        .DEPTH       (8),
        .SAMPLE_BITS (24)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .en       (en),
        .clk_div  (clk_div),
        .SD       (SD),
        .SCK      (SCK),
        .WS       (WS),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .flush    (flush),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 HCLK = ~HCLK;

    // Vector table: each record is a left-slot word driven by the mic and
    // the 32-bit sign-extended value expected on rd_data.
    typedef struct {
        logic [23:0] left;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Microphone model. It advances its bit position on each falling SCK.
    // It restarts whenever the bus is idled by en=0 or by reset.
    int mic_bit = 0;
    int fc      = 0;

    always @(negedge SCK or negedge en or negedge HRESETn) begin
        if (!en || !HRESETn) begin
            mic_bit = 0;
            fc      = 0;
        end else if (mic_bit == 63) begin
            mic_bit = 0;
            fc      = fc + 1;
        end else begin
            mic_bit = mic_bit + 1;
        end
    end

    logic [23:0] mic_left;
    always @* begin
        mic_left = (fc < 10) ? vecs[fc].left : 24'h000000;
        SD = 1'b1;
        if (mic_bit >= 1 && mic_bit <= 24) begin
            SD = mic_left[5'(24 - mic_bit)];
        end
    end

    initial begin
        int sck_r1, sck_r2, ws_r1, ws_f1, ws_r2, l1, l2;
        logic prev_sck, prev_ws;
        logic [31:0] rd_at_l1;

        vecs[0] = '{24'h800001, 32'hFF800001};
        vecs[1] = '{24'h123456, 32'h00123456};
        vecs[2] = '{24'h7FFFFF, 32'h007FFFFF};
        vecs[3] = '{24'hFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{24'h000000, 32'h00000000};
        vecs[5] = '{24'hA5A5A5, 32'hFFA5A5A5};
        vecs[6] = '{24'h5A5A5A, 32'h005A5A5A};
        vecs[7] = '{24'h000001, 32'h00000001};
        vecs[8] = '{24'hC00000, 32'hFFC00000};
        vecs[9] = '{24'h0F0F0F, 32'h000F0F0F};

        HRESETn = 1'b1;
        en      = 1'b0;
        clk_div = 8'd1;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;

        // ---- reset state ----
        #1 HRESETn = 1'b0;
        #1;
        check("rst_sck",   32'(SCK),      32'd0);
        check("rst_ws",    32'(WS),       32'd0);
        check("rst_level", 32'(level),    32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_rd",    rd_data,       32'd0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1 en = 1'b1;

        // ---- SCK/WS timing and first two captures ----
        sck_r1 = -1; sck_r2 = -1; ws_r1 = -1; ws_f1 = -1; ws_r2 = -1;
        l1 = -1; l2 = -1; rd_at_l1 = '0;
        prev_sck = 1'b0; prev_ws = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge HCLK);
            #1;
            if (SCK && !prev_sck) begin
                if (sck_r1 < 0) sck_r1 = c;
                else if (sck_r2 < 0) sck_r2 = c;
            end
            if (WS && !prev_ws) begin
                if (ws_r1 < 0) ws_r1 = c;
                else if (ws_r2 < 0) ws_r2 = c;
            end
            if (!WS && prev_ws && ws_f1 < 0) ws_f1 = c;
            if (level == 5'd1 && l1 < 0) begin
                l1 = c;
                rd_at_l1 = rd_data;
            end
            if (level == 5'd2 && l2 < 0) l2 = c;
            prev_sck = SCK;
            prev_ws  = WS;
        end
        $display("timing: sck_rise=%0d,%0d ws_rise=%0d ws_fall=%0d ws_rise2=%0d push=%0d,%0d",
                 sck_r1, sck_r2, ws_r1, ws_f1, ws_r2, l1, l2);
        check("sck_first_rise",  32'(sck_r1), 32'd2);
        check("sck_second_rise", 32'(sck_r2), 32'd6);
        check("ws_first_rise",   32'(ws_r1),  32'd128);
        check("ws_first_fall",   32'(ws_f1),  32'd256);
        check("ws_second_rise",  32'(ws_r2),  32'd384);
        check("push0_cycle",     32'(l1),     32'd98);
        check("push0_data",      rd_at_l1,    32'hFF800001);
        check("push1_cycle",     32'(l2),     32'd354);
        check("level_after2",    32'(level),  32'd2);

        // ---- fill past full: frame 8 overflows ----
        tick(1745);   // cycle 2145, one before the frame-8 push
        check("fill_level",     32'(level),    32'd8);
        check("fill_full",      32'(full),     32'd1);
        check("fill_ovf_pre",   32'(overflow), 32'd0);
        tick(1);      // cycle 2146: frame-8 push dropped
        check("ovf_set",        32'(overflow), 32'd1);
        check("ovf_level",      32'(level),    32'd8);
        tick(54);
        en = 1'b0;
        tick(1);
        check("dis_sck",        32'(SCK), 32'd0);
        check("dis_ws",         32'(WS),  32'd0);
        tick(10);
        check("dis_keep_level", 32'(level),    32'd8);
        check("dis_keep_ovf",   32'(overflow), 32'd1);

        for (int i = 0; i < 8; i++) begin
            $display("pop %0d: rd_data=0x%08h level=%0d", i, rd_data, level);
            check($sformatf("ovf_pop%0d_data", i), rd_data, vecs[i].exp);
            check($sformatf("ovf_pop%0d_level", i), 32'(level), 32'(8 - i));
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_rd",    rd_data,    32'd0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("pop_empty_ignored", 32'(level), 32'd0);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // ---- push and pop in the same cycle while full, then flush with a push ----
        en = 1'b1;
        tick(2145);
        check("full2_level", 32'(level), 32'd8);
        check("full2_head",  rd_data,    vecs[0].exp);
        rd_en = 1'b1;
        tick(1);      // cycle 2146: push of frame 8 with a pop
        rd_en = 1'b0;
        check("pushpop_level", 32'(level),    32'd8);
        check("pushpop_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            $display("pop %0d: rd_data=0x%08h level=%0d", i, rd_data, level);
            check($sformatf("pp_pop%0d_data", i), rd_data, vecs[i + 1].exp);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
        end
        check("pp_drained", 32'(level), 32'd0);
        tick(247);    // cycle 2401
        flush = 1'b1;
        tick(1);      // cycle 2402: frame-9 push with flush
        flush = 1'b0;
        check("flush_level", 32'(level),    32'd0);
        check("flush_empty", 32'(empty),    32'd1);
        check("flush_ovf",   32'(overflow), 32'd0);
        en = 1'b0;

        // ---- disable mid-word at bit_cnt 12 ----
        tick(5);
        en = 1'b1;
        tick(50);     // bit_cnt 12 with SCK high
        check("mid_sck_high", 32'(SCK), 32'd1);
        en = 1'b0;
        tick(1);
        check("mid_sck_low", 32'(SCK), 32'd0);
        check("mid_ws_low",  32'(WS),  32'd0);
        tick(200);
        check("mid_no_push", 32'(level), 32'd0);
        en = 1'b1;
        tick(97);
        check("re_no_early_push", 32'(level), 32'd0);
        tick(1);
        $display("capture after re-enable: rd_data=0x%08h level=%0d", rd_data, level);
        check("re_push_level", 32'(level), 32'd1);
        check("re_push_data",  rd_data,    32'hFF800001);

        // ---- asynchronous reset mid-frame with 3 samples queued ----
        tick(614);    // cycle 712: right slot of frame 2
        check("pre_rst_ws",    32'(WS),    32'd1);
        check("pre_rst_level", 32'(level), 32'd3);
        #3 HRESETn = 1'b0;
        #1;
        check("async_rst_sck",   32'(SCK),      32'd0);
        check("async_rst_ws",    32'(WS),       32'd0);
        check("async_rst_level", 32'(level),    32'd0);
        check("async_rst_empty", 32'(empty),    32'd1);
        check("async_rst_ovf",   32'(overflow), 32'd0);
        check("async_rst_rd",    rd_data,       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx_fifo.md
I2S_RX_FIFO -- requirements
Module: i2s_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter SAMPLE_BITS, default 24, meaning captured bits per sample (1..31).
REQ-003 SHALL have port HCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port HRESETn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  in  1  capture enable.
REQ-006 SHALL have port clk_div  in  8  SCK divider; SCK period = 2*(clk_div+1) HCLK cycles.
REQ-007 SHALL have port SD  in  1  I2S serial data from microphone.
REQ-008 SHALL have port SCK  out  1  I2S bit clock, registered.
REQ-009 SHALL have port WS  out  1  I2S word select, registered; 0 = left slot.
REQ-010 SHALL have port rd_en  in  1  pop request from the AHB-lite I2S wrapper.
REQ-011 SHALL have port rd_data  out  32  FIFO head sample, sign-extended (show-ahead).
REQ-012 SHALL have port empty  out  1  FIFO empty.
REQ-013 SHALL have port full  out  1  FIFO full.
REQ-014 SHALL have port level  out  5  current FIFO occupancy, 0..DEPTH.
REQ-015 SHALL have port flush  in  1  synchronous FIFO clear.
REQ-016 SHALL have port overflow  out  1  sticky dropped-sample flag.
REQ-017 SHALL have port clr_ovf  in  1  clears overflow.

Function
REQ-018 SHALL run div_cnt 0..clk_div on HCLK while en=1; SCK toggles in the cycle div_cnt==clk_div, div_cnt then returns to 0.
REQ-019 SHALL keep a 6-bit bit_cnt incremented on each SCK falling toggle, wrapping 63->0; WS = bit_cnt[5] (registered with SCK, 32 SCK per slot, 64 per frame).
REQ-020 SHALL sample SD only on SCK rising toggles, left slot only (WS=0); rising edge at bit_cnt 0 is the I2S delay bit and is ignored.
REQ-021 SHALL shift SD MSB-first on rising edges with bit_cnt 1..SAMPLE_BITS; rising edges at bit_cnt > SAMPLE_BITS and all right-slot edges are ignored.
REQ-022 SHALL push the completed sample, sign-extended from bit SAMPLE_BITS-1 to 32 bits, in the same HCLK cycle as the rising edge at bit_cnt==SAMPLE_BITS (shifted word including that cycle's SD bit).
REQ-023 SHALL, while en=0, force SCK=0, WS=0, div_cnt=0, bit_cnt=0 and clear the shift register; FIFO contents, level and overflow are retained.
REQ-024 SHALL, on en deasserting mid-frame, discard the partial sample; on re-enable the first SCK toggle is rising at bit_cnt=0 (delay bit).
REQ-025 SHALL change clk_div only while en=0; behaviour on mid-run change is undefined.
REQ-026 SHALL pop when rd_en=1 and empty=0; rd_en while empty is ignored; rd_data presents the new head the cycle after a pop; rd_data=0 when empty.
REQ-027 SHALL, on push while full without a same-cycle pop, drop the sample, leave contents unchanged and set overflow.
REQ-028 SHALL, on simultaneous push and pop, perform both (including when full): level unchanged, no overflow.
REQ-029 SHALL, on flush, set level=0, empty=1 and reset pointers; flush takes priority over a same-cycle push and pop; overflow is unaffected.
REQ-030 SHALL clear overflow on clr_ovf unless an overflow event occurs the same cycle (set wins).
REQ-031 SHALL derive empty = (level==0), full = (level==DEPTH), combinationally from registered level.

Reset
REQ-032 SHALL, on HRESETn=0, asynchronously force SCK=0, WS=0, div_cnt=0, bit_cnt=0, shift=0, level=0, pointers=0, overflow=0; outputs empty=1, full=0, rd_data=0.
REQ-033 SHALL resume operation on the first HCLK rising edge after HRESETn deasserts, with en sampled then.

Verification
REQ-034 Reset asserted mid-frame with 3 samples queued -> SCK=0, WS=0, level=0, empty=1, overflow=0, rd_data=0 immediately, without a clock edge.
REQ-035 clk_div=1, en=1 -> SCK period 4 HCLK, first SCK toggle rising, WS period 256 HCLK, WS high 128 HCLK.
REQ-036 Mic model drives left slot 0x800001, right slot 0xFFFFFF -> one push, rd_data=0xFF800001, level=1; next frame left 0x123456 -> second entry 0x00123456.
REQ-037 9 frames with no pops -> level=8, full=1, overflow=1, popping yields the first 8 samples in order; clr_ovf -> overflow=0.
REQ-038 FIFO full, rd_en=1 in the push cycle -> level stays 8, overflow stays 0, new sample becomes tail; flush with push same cycle -> level=0.
REQ-039 en dropped at bit_cnt=12 then re-raised -> SCK/WS low the next cycle, no push for the partial word, next full left slot captured correctly.
